// File: rtl/ufi_pkg.sv
// ============================================================================
//  Module      : ufi_pkg
//  Description : Shared types, constants and helpers for the UFI bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ufi_pkg;

    // Arbiter FSM encoding: IDLE, GRANT, RELEASE
    typedef logic [1:0] ufi_state_t;
    localparam ufi_state_t c_ST_IDLE    = 2'd0;
    localparam ufi_state_t c_ST_GRANT   = 2'd1;
    localparam ufi_state_t c_ST_RELEASE = 2'd2;

    localparam int c_MODE_RR    = 0;
    localparam int c_MODE_FIXED = 1;

    // LSB position of element idx inside a flattened vector of width-wide slices
    function automatic int ufi_slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

    function automatic int ufi_clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ufi_bus_arbiter_picker.sv
// ============================================================================
//  Module      : ufi_rr_picker
//  Description : Combinational winner selection, round-robin or fixed priority.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ufi_rr_picker
    import ufi_pkg::*;
#(
    parameter int pMasterNum = 4,
    parameter int pIdxW      = 3,
    parameter int pMode      = c_MODE_RR
) (
    input  logic [pMasterNum-1:0] req_i,
    input  logic [pIdxW-1:0]      ptr_i,
    output logic [pMasterNum-1:0] gnt_o,
    output logic [pIdxW-1:0]      idx_o
);

    int base;
    int best;
    int best_off;
    int off;

    // Smallest rotated distance from the pointer wins; fixed mode pins the pointer at 0.
    always_comb begin
        base     = (pMode == c_MODE_FIXED) ? 0 : int'(ptr_i);
        best     = 0;
        best_off = pMasterNum;
        off      = 0;
        for (int m = 0; m < pMasterNum; m++) begin
            off = (m + pMasterNum - base) % pMasterNum;
            if (req_i[m] && (off < best_off)) begin
                best_off = off;
                best     = m;
            end
        end
        gnt_o = '0;
        for (int m = 0; m < pMasterNum; m++) begin
            gnt_o[m] = (best_off < pMasterNum) && (best == m);
        end
        idx_o = pIdxW'(best);
    end

endmodule

`default_nettype wire

// File: rtl/ufi_bus_arbiter.sv
// ============================================================================
//  Module      : ufi_bus_arbiter
//  Description : N-master / single-slave UFI arbiter with burst capping and
//                ID-tagged read-data return.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ufi_bus_arbiter
    import ufi_pkg::*;
#(
    parameter int    pMasterNum   = 4,
    parameter int    pUfiBusWidth = 12,
    parameter int    pBusAdrsBit  = 32,
    parameter int    pUfiIdNumber = 3,
    parameter int    pBurstMax    = 16,
    parameter string pArbMode     = "rr"
) (
    input  logic                               iUfiClk,
    input  logic                               iUfiRst,
    input  logic [pMasterNum*pUfiBusWidth-1:0] iMUfiWd,
    input  logic [pMasterNum*pBusAdrsBit-1:0]  iMUfiAdrs,
    input  logic [pMasterNum-1:0]              iMUfiWEd,
    input  logic [pMasterNum-1:0]              iMUfiREd,
    input  logic [pMasterNum-1:0]              iMUfiVd,
    input  logic [pMasterNum-1:0]              iMUfiCmd,
    output logic [pMasterNum-1:0]              oMUfiRdy,
    output logic [pUfiBusWidth-1:0]            oMUfiRd,
    output logic [pMasterNum-1:0]              oMUfiEdd,
    output logic [pMasterNum-1:0]              oMUfiGnt,
    output logic [pUfiBusWidth-1:0]            oSUfiWd,
    output logic [pBusAdrsBit-1:0]             oSUfiAdrs,
    output logic                               oSUfiWEd,
    output logic                               oSUfiREd,
    output logic                               oSUfiCmd,
    output logic [pUfiIdNumber-1:0]            oSUfiIdO,
    input  logic [pUfiBusWidth-1:0]            iSUfiRd,
    input  logic                               iSUfiREd,
    input  logic [pUfiIdNumber-1:0]            iSUfiIdI,
    input  logic                               iSUfiRdy
);

    localparam int c_MODE = (pArbMode == "fixed") ? c_MODE_FIXED : c_MODE_RR;
    localparam int c_BCW  = ufi_clog2(pBurstMax + 1);
    localparam logic [c_BCW-1:0]        c_BURST_MAX = c_BCW'(pBurstMax);
    localparam logic [pUfiIdNumber-1:0] c_LAST_IDX  = pUfiIdNumber'(pMasterNum - 1);

    ufi_state_t                state_q, state_d;
    logic [pUfiIdNumber-1:0]   gnt_idx_q, gnt_idx_d;
    logic [pMasterNum-1:0]     gnt_oh_q, gnt_oh_d;
    logic [pUfiIdNumber-1:0]   ptr_q, ptr_d;
    logic [c_BCW-1:0]          burst_q, burst_d;
    logic [pUfiBusWidth-1:0]   rd_q, rd_d;
    logic [pMasterNum-1:0]     edd_q, edd_d;
    logic                      err_q, err_d;

    logic [pMasterNum-1:0]     w_pick_oh;
    logic [pUfiIdNumber-1:0]   w_pick_idx;
    logic [pUfiBusWidth-1:0]   w_wd;
    logic [pBusAdrsBit-1:0]    w_adrs;
    logic                      w_wed, w_red, w_cmd, w_vd;
    logic                      w_in_grant, w_beat, w_id_ok;
    logic [c_BCW-1:0]          w_burst_inc;

    ufi_rr_picker #(
        .pMasterNum (pMasterNum),
        .pIdxW      (pUfiIdNumber),
        .pMode      (c_MODE)
    ) u_picker (
        .req_i (iMUfiVd),
        .ptr_i (ptr_q),
        .gnt_o (w_pick_oh),
        .idx_o (w_pick_idx)
    );

    // One-hot OR mux of the granted master's signals
    always_comb begin
        w_wd   = '0;
        w_adrs = '0;
        w_wed  = 1'b0;
        w_red  = 1'b0;
        w_cmd  = 1'b0;
        w_vd   = 1'b0;
        for (int m = 0; m < pMasterNum; m++) begin
            if (gnt_oh_q[m]) begin
                w_wd   = w_wd   | iMUfiWd[ufi_slice_lsb(m, pUfiBusWidth) +: pUfiBusWidth];
                w_adrs = w_adrs | iMUfiAdrs[ufi_slice_lsb(m, pBusAdrsBit) +: pBusAdrsBit];
                w_wed  = w_wed  | iMUfiWEd[m];
                w_red  = w_red  | iMUfiREd[m];
                w_cmd  = w_cmd  | iMUfiCmd[m];
                w_vd   = w_vd   | iMUfiVd[m];
            end
        end
    end

    assign w_in_grant  = (state_q == c_ST_GRANT);
    assign w_beat      = w_in_grant & (w_wed | w_red) & iSUfiRdy;
    assign w_burst_inc = burst_q + 1'b1;

    assign oSUfiWd   = w_in_grant ? w_wd   : '0;
    assign oSUfiAdrs = w_in_grant ? w_adrs : '0;
    assign oSUfiWEd  = w_in_grant & w_wed & w_vd;
    assign oSUfiREd  = w_in_grant & w_red & w_vd;
    assign oSUfiCmd  = w_in_grant & w_cmd;
    assign oSUfiIdO  = w_in_grant ? gnt_idx_q : '0;
    assign oMUfiRdy  = w_in_grant ? (gnt_oh_q & {pMasterNum{iSUfiRdy}}) : '0;
    assign oMUfiGnt  = w_in_grant ? gnt_oh_q : '0;
    assign oMUfiRd   = rd_q;
    assign oMUfiEdd  = edd_q;

    always_comb begin
        state_d   = state_q;
        gnt_idx_d = gnt_idx_q;
        gnt_oh_d  = gnt_oh_q;
        ptr_d     = ptr_q;
        burst_d   = burst_q;
        case (state_q)
            c_ST_IDLE: begin
                if (|iMUfiVd) begin
                    state_d   = c_ST_GRANT;
                    gnt_oh_d  = w_pick_oh;
                    gnt_idx_d = w_pick_idx;
                end
            end
            c_ST_GRANT: begin
                if (w_beat && (burst_q != c_BURST_MAX)) begin
                    burst_d = w_burst_inc;
                end
                if (!w_vd || (w_beat && (w_burst_inc == c_BURST_MAX))) begin
                    state_d = c_ST_RELEASE;
                end
            end
            c_ST_RELEASE: begin
                state_d  = c_ST_IDLE;
                burst_d  = '0;
                gnt_oh_d = '0;
                ptr_d    = (gnt_idx_q == c_LAST_IDX) ? '0 : gnt_idx_q + 1'b1;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // Read return ignores grant state; out-of-range IDs only raise the sticky error
    always_comb begin
        w_id_ok = (int'(iSUfiIdI) < pMasterNum);
        rd_d    = rd_q;
        err_d   = err_q | (iSUfiREd & ~w_id_ok);
        for (int m = 0; m < pMasterNum; m++) begin
            edd_d[m] = iSUfiREd && (int'(iSUfiIdI) == m);
        end
        if (iSUfiREd && w_id_ok) begin
            rd_d = iSUfiRd;
        end
    end

    always_ff @(posedge iUfiClk) begin
        if (iUfiRst) begin
            state_q   <= c_ST_IDLE;
            gnt_idx_q <= '0;
            gnt_oh_q  <= '0;
            ptr_q     <= '0;
            burst_q   <= '0;
            rd_q      <= '0;
            edd_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_oh_q  <= gnt_oh_d;
            ptr_q     <= ptr_d;
            burst_q   <= burst_d;
            rd_q      <= rd_d;
            edd_q     <= edd_d;
            err_q     <= err_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ufi_bus_arbiter.sv
// ============================================================================
//  Module      : tb_ufi_bus_arbiter
//  Description : Directed bench for ufi_bus_arbiter (round-robin and fixed).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ufi_bus_arbiter;

    localparam int N  = 4;
    localparam int W  = 12;
    localparam int AW = 32;
    localparam int IW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N*W-1:0]  wd;
    logic [N*AW-1:0] adrs;
    logic [N-1:0]    wed, red, vd, cmd;
    logic [W-1:0]    srd;
    logic            sred;
    logic [IW-1:0]   sid;
    logic            srdy;

    logic [N-1:0]  rdy_rr, edd_rr, gnt_rr, rdy_fx, edd_fx, gnt_fx;
    logic [W-1:0]  rd_rr, swd_rr, rd_fx, swd_fx;
    logic [AW-1:0] sadrs_rr, sadrs_fx;
    logic          swed_rr, sred_rr, scmd_rr, swed_fx, sred_fx, scmd_fx;
    logic [IW-1:0] sido_rr, sido_fx;

    ufi_bus_arbiter #(.pMasterNum(N), .pUfiBusWidth(W), .pBusAdrsBit(AW),
                      .pUfiIdNumber(IW), .pBurstMax(16), .pArbMode("rr")) u_dut_rr (
        .iUfiClk(clk), .iUfiRst(rst), .iMUfiWd(wd), .iMUfiAdrs(adrs),
        .iMUfiWEd(wed), .iMUfiREd(red), .iMUfiVd(vd), .iMUfiCmd(cmd),
        .oMUfiRdy(rdy_rr), .oMUfiRd(rd_rr), .oMUfiEdd(edd_rr), .oMUfiGnt(gnt_rr),
        .oSUfiWd(swd_rr), .oSUfiAdrs(sadrs_rr), .oSUfiWEd(swed_rr), .oSUfiREd(sred_rr),
        .oSUfiCmd(scmd_rr), .oSUfiIdO(sido_rr), .iSUfiRd(srd), .iSUfiREd(sred),
        .iSUfiIdI(sid), .iSUfiRdy(srdy)
    );

    ufi_bus_arbiter #(.pMasterNum(N), .pUfiBusWidth(W), .pBusAdrsBit(AW),
                      .pUfiIdNumber(IW), .pBurstMax(16), .pArbMode("fixed")) u_dut_fx (
        .iUfiClk(clk), .iUfiRst(rst), .iMUfiWd(wd), .iMUfiAdrs(adrs),
        .iMUfiWEd(wed), .iMUfiREd(red), .iMUfiVd(vd), .iMUfiCmd(cmd),
        .oMUfiRdy(rdy_fx), .oMUfiRd(rd_fx), .oMUfiEdd(edd_fx), .oMUfiGnt(gnt_fx),
        .oSUfiWd(swd_fx), .oSUfiAdrs(sadrs_fx), .oSUfiWEd(swed_fx), .oSUfiREd(sred_fx),
        .oSUfiCmd(scmd_fx), .oSUfiIdO(sido_fx), .iSUfiRd(srd), .iSUfiREd(sred),
        .iSUfiIdI(sid), .iSUfiRdy(srdy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    typedef struct {
        logic [N-1:0]  vd;
        logic [N-1:0]  wed;
        logic          rdy;
        logic [N-1:0]  e_gnt;
        logic [N-1:0]  e_rdy;
        logic          e_wed;
        logic [IW-1:0] e_ido;
    } vec_t;

    vec_t tbl[18];

    task automatic set_row(input int i, input logic [N-1:0] v, input logic [N-1:0] w,
                           input logic r, input logic [N-1:0] eg, input logic [N-1:0] er,
                           input logic ew, input logic [IW-1:0] ei);
        tbl[i].vd = v; tbl[i].wed = w; tbl[i].rdy = r;
        tbl[i].e_gnt = eg; tbl[i].e_rdy = er; tbl[i].e_wed = ew; tbl[i].e_ido = ei;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int           ids[4];
        logic [W-1:0] dat[4];
        logic [N-1:0] exp_edd;
        int           gseq[$], beats[$], gaps[$];
        int           cur_beats, gap, fx_bad, fx_grants;
        logic [N-1:0] prev, fx_prev;
        bit           done;

        // master 2: 5-beat write, then master 1 with Rdy toggling 1010
        set_row( 0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 3'd0);
        set_row( 1, 4'b0100, 4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b0, 3'd0);
        for (int i = 2; i <= 6; i++)
            set_row(i, 4'b0100, 4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1, 3'd2);
        set_row( 7, 4'b0000, 4'b0000, 1'b1, 4'b0100, 4'b0100, 1'b0, 3'd2);
        set_row( 8, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 3'd0);
        set_row( 9, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 3'd0);
        set_row(10, 4'b0010, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 3'd0);
        set_row(11, 4'b0010, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1, 3'd1);
        set_row(12, 4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1, 3'd1);
        set_row(13, 4'b0010, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1, 3'd1);
        set_row(14, 4'b0010, 4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b1, 3'd1);
        set_row(15, 4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b0, 3'd1);
        set_row(16, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd0);
        set_row(17, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 3'd0);

        rst = 1'b1; vd = '0; wed = '0; red = '0; cmd = 4'b0110;
        srd = '0; sred = 1'b0; sid = '0; srdy = 1'b0;
        for (int i = 0; i < N; i++) begin
            wd[i*W +: W]    = W'(12'h111 * (i + 1));
            adrs[i*AW +: AW] = 32'h1000 + i;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset gnt",  gnt_rr,   0);
        check("reset rdy",  rdy_rr,   0);
        check("reset edd",  edd_rr,   0);
        check("reset swed", swed_rr,  0);
        check("reset ido",  sido_rr,  0);
        check("reset adrs", sadrs_rr, 0);
        step();
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            step();
            vd = tbl[i].vd; wed = tbl[i].wed; srdy = tbl[i].rdy;
            @(negedge clk);
            check($sformatf("row%0d gnt", i),  gnt_rr,  tbl[i].e_gnt);
            check($sformatf("row%0d rdy", i),  rdy_rr,  tbl[i].e_rdy);
            check($sformatf("row%0d swed", i), swed_rr, tbl[i].e_wed);
            check($sformatf("row%0d ido", i),  sido_rr, tbl[i].e_ido);
            check($sformatf("row%0d cmd", i),  scmd_rr, |(tbl[i].e_gnt & cmd));
            if (tbl[i].e_gnt != 0) begin
                check($sformatf("row%0d adrs", i), sadrs_rr, 32'h1000 + tbl[i].e_ido);
                check($sformatf("row%0d wd", i), swd_rr, W'(12'h111 * (tbl[i].e_ido + 1)));
            end
        end

        // read return: IDs 3,0,3,5, one-cycle latency
        ids = '{3, 0, 3, 5};
        dat = '{12'h0A1, 12'h0B2, 12'h0C3, 12'h0D4};
        for (int i = 0; i <= 4; i++) begin
            step();
            if (i < 4) begin sred = 1'b1; sid = IW'(ids[i]); srd = dat[i]; end
            else       begin sred = 1'b0; sid = '0; srd = '0; end
            @(negedge clk);
            if (i > 0) begin
                exp_edd = (ids[i-1] < N) ? N'(1 << ids[i-1]) : '0;
                check($sformatf("rdret%0d edd", i - 1), edd_rr, exp_edd);
                if (exp_edd != 0) check($sformatf("rdret%0d data", i - 1), rd_rr, dat[i-1]);
            end
        end

        // reset mid-burst at beat 7 (rr pointer is 2 here, so master 0 wins only if reset cleared it)
        step(); vd = 4'b0100; wed = 4'b0100; srdy = 1'b1;
        for (int b = 1; b <= 7; b++) step();
        @(negedge clk);
        check("midrst beat7 gnt", gnt_rr, 4'b0100);
        step(); rst = 1'b1; vd = 4'b0101; wed = 4'b0101;
        step(); rst = 1'b0;
        @(negedge clk);
        check("midrst gnt",  gnt_rr,   0);
        check("midrst rdy",  rdy_rr,   0);
        check("midrst swed", swed_rr,  0);
        check("midrst adrs", sadrs_rr, 0);
        check("midrst edd",  edd_rr,   0);
        step();
        @(negedge clk);
        check("postrst gnt", gnt_rr,  4'b0001);
        check("postrst ido", sido_rr, 0);

        // all masters streaming: rr rotation vs fixed priority
        step(); rst = 1'b1; vd = 4'b1111; wed = 4'b1111; srdy = 1'b1;
        step(); rst = 1'b0;
        cur_beats = 0; gap = 0; prev = '0; fx_prev = '0;
        fx_bad = 0; fx_grants = 0; done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (gnt_rr != 0 && prev == 0) begin
                gseq.push_back(oh2i(gnt_rr)); gaps.push_back(gap); cur_beats = 0;
            end
            if (gnt_rr != 0) begin
                if (swed_rr && ((rdy_rr & gnt_rr) != 0)) cur_beats++;
                gap = 0;
            end else gap++;
            if (gnt_rr == 0 && prev != 0) begin
                beats.push_back(cur_beats);
                if (beats.size() == 5) done = 1'b1;
            end
            prev = gnt_rr;
            if (gnt_fx != 0 && gnt_fx != 4'b0001) fx_bad++;
            if (gnt_fx == 4'b0001 && fx_prev == 0) fx_grants++;
            fx_prev = gnt_fx;
        end
        check("rr five grants seen", 32'(done), 1);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("rr grant%0d idx", k),   (k < gseq.size())  ? gseq[k]  : -1, k % N);
            check($sformatf("rr grant%0d beats", k), (k < beats.size()) ? beats[k] : -1, 16);
            if (k > 0)
                check($sformatf("rr gap%0d", k), (k < gaps.size()) ? gaps[k] : -1, 2);
        end
        check("fixed other grants", fx_bad, 0);
        check("fixed master0 regrant", 32'(fx_grants >= 4), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
